// File: rtl/regfile_occurrence_scanner_pkg.sv
// Shared types and helpers for the register-file occurrence scanner.
// Holds the FSM state encoding, the scan mode values and the vector-width helper.
package regfile_occurrence_scanner_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      FINISH = 2'd2
   } state_e;

   localparam logic MODE_XOR = 1'b0;
   localparam logic MODE_OR  = 1'b1;

   function automatic int vec_w(input int width);
      return 1 << width;
   endfunction

endpackage

// File: rtl/regfile_occurrence_scanner_if.sv
// Bus between a controller and the occurrence scanner: register-file writes,
// scan request/completion and the registered scan results.
interface regfile_occurrence_scanner_if #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 3
);
   import regfile_occurrence_scanner_pkg::*;

   localparam int VEC_W = vec_w(WIDTH);
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // start is a request sampled only while busy is low; once taken, busy stays
   // high until the single-cycle done pulse, and extra starts are simply dropped.
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             start;
   logic             mode;
   logic             busy;
   logic             done;
   logic             wr_err;
   logic [VEC_W-1:0] occ_vec;
   logic             parity;
   logic [WIDTH:0]   ones;
   logic [1:0]       fsm_state;

   modport master (
      output wr_en, wr_addr, wr_data, start, mode,
      input  busy, done, wr_err, occ_vec, parity, ones, fsm_state
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, mode,
      output busy, done, wr_err, occ_vec, parity, ones, fsm_state
   );

endinterface

// File: rtl/regfile_occurrence_scanner_btn_toggle_sync.sv
// Push-button conditioner: 2-flop synchroniser, rising-edge detect and a
// toggle register that flips once per detected press.
module btn_toggle_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic toggle
);

   logic sync_1, sync_2, sync_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         sync_prev <= 1'b0;
         toggle    <= 1'b0;
      end else begin
         sync_1    <= btn;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
         if (sync_2 && !sync_prev)
            toggle <= ~toggle;
      end
   end

endmodule

// File: rtl/regfile_occurrence_scanner.sv
// DEPTH x WIDTH register file scanned one entry per clock into a 2^WIDTH-bit
// occurrence vector (XOR = odd count, OR = presence), with parity/popcount summary.
module regfile_occurrence_scanner
   import regfile_occurrence_scanner_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 3,
   parameter int LED_W = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   regfile_occurrence_scanner_if.slave bus,
   input  logic                        PB1,
   output logic [LED_W-1:0]            led
);

   localparam int VEC_W = vec_w(WIDTH);
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SUM_W = (WIDTH + 2 > LED_W) ? WIDTH + 2 : LED_W;

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_SCAN   = SCAN;
   localparam logic [1:0] ST_FINISH = FINISH;

   logic [1:0]       state;
   logic [AW-1:0]    idx;
   logic [VEC_W-1:0] acc;
   logic             mode_q;
   logic [WIDTH-1:0] rf [DEPTH];
   logic             par_c;
   logic [WIDTH:0]   ones_c;
   logic             disp_sel;
   logic [SUM_W-1:0] summary;

   assign bus.fsm_state = state;

   always_comb begin
      ones_c = '0;
      for (int i = 0; i < VEC_W; i++)
         ones_c = ones_c + (WIDTH + 1)'(acc[i]);
   end

   assign par_c = ^acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         acc         <= '0;
         mode_q      <= MODE_XOR;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.wr_err  <= 1'b0;
         bus.occ_vec <= '0;
         bus.parity  <= 1'b0;
         bus.ones    <= '0;
         for (int i = 0; i < DEPTH; i++)
            rf[i] <= '0;
      end else begin
         bus.done   <= 1'b0;
         // Writes are only legal while idle so the scan always sees a stable file.
         bus.wr_err <= bus.wr_en && (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (bus.wr_en && ({1'b0, bus.wr_addr} < (AW + 1)'(DEPTH)))
                  rf[bus.wr_addr] <= bus.wr_data;
               if (bus.start) begin
                  state    <= ST_SCAN;
                  mode_q   <= bus.mode;
                  acc      <= '0;
                  idx      <= '0;
                  bus.busy <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (mode_q == MODE_OR)
                  acc[rf[idx]] <= 1'b1;
               else
                  acc[rf[idx]] <= ~acc[rf[idx]];
               if (idx == AW'(DEPTH - 1))
                  state <= ST_FINISH;
               else
                  idx <= idx + 1'b1;
            end
            ST_FINISH: begin
               bus.occ_vec <= acc;
               bus.parity  <= par_c;
               bus.ones    <= ones_c;
               bus.done    <= 1'b1;
               bus.busy    <= 1'b0;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   btn_toggle_sync u_btn (
      .clk    (clk),
      .rst    (rst),
      .btn    (PB1),
      .toggle (disp_sel)
   );

   // Summary view is {ones, parity}, zero-padded or truncated to the LED bus.
   assign summary = SUM_W'({bus.ones, bus.parity});
   assign led     = disp_sel ? summary[LED_W-1:0] : bus.occ_vec[LED_W-1:0];

endmodule

// File: tb/tb_regfile_occurrence_scanner.sv
// Directed bench: table of hand-computed scans on the 8x3 instance, hand-written
// corner sequences, and a small random sweep on a 5x4 instance against a model.
module tb_regfile_occurrence_scanner;
   import regfile_occurrence_scanner_pkg::*;

   logic       clk;
   logic       rst;
   logic       pb8, pb5;
   logic [7:0] led8, led5;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int t0 = 0;

   logic [7:0]  exp_q[$];
   logic [15:0] exp5_q[$];
   logic [2:0]  mdl8 [8];
   logic [3:0]  mdl5 [5];

   typedef struct packed {
      logic [7:0][2:0] data;
      logic            mode;
      logic [7:0]      exp_vec;
      logic [3:0]      exp_ones;
      logic            exp_par;
   } vec_t;

   localparam int NV = 7;
   vec_t tbl [NV];

   regfile_occurrence_scanner_if #(.DEPTH(8), .WIDTH(3)) bus8 ();
   regfile_occurrence_scanner_if #(.DEPTH(5), .WIDTH(4)) bus5 ();

   regfile_occurrence_scanner #(.DEPTH(8), .WIDTH(3), .LED_W(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave),
      .PB1 (pb8),
      .led (led8)
   );

   regfile_occurrence_scanner #(.DEPTH(5), .WIDTH(4), .LED_W(8)) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5.slave),
      .PB1 (pb5),
      .led (led5)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] model8(input logic m);
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < 8; i++)
         if (m == MODE_OR) v[mdl8[i]] = 1'b1;
         else v[mdl8[i]] = ~v[mdl8[i]];
      return v;
   endfunction

   function automatic logic [15:0] model5(input logic m);
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < 5; i++)
         if (m == MODE_OR) v[mdl5[i]] = 1'b1;
         else v[mdl5[i]] = ~v[mdl5[i]];
      return v;
   endfunction

   // driver tasks, 8x3 instance
   task automatic write8(input int a, input logic [2:0] d);
      bus8.wr_en   = 1'b1;
      bus8.wr_addr = 3'(a);
      bus8.wr_data = d;
      tick(1);
      bus8.wr_en = 1'b0;
      mdl8[a] = d;
   endtask

   task automatic load8(input logic [7:0][2:0] data);
      for (int i = 0; i < 8; i++)
         write8(i, data[i]);
   endtask

   task automatic kick8(input logic m);
      bus8.start = 1'b1;
      bus8.mode  = m;
      tick(1);
      bus8.start = 1'b0;
      t0 = cyc;
      check("busy_rise", bus8.busy, 1);
      check("state_scan", bus8.fsm_state, 1);
   endtask

   task automatic finish8(input string nm, input logic m, input logic [3:0] eo, input logic ep);
      int n;
      logic [7:0] ev;
      n = 0;
      while (!bus8.done && n < 40) begin
         tick(1);
         n++;
      end
      check({nm, "_done"}, bus8.done, 1);
      check({nm, "_lat"}, cyc - t0, 9);
      ev = exp_q.pop_front();
      check({nm, "_vec"}, bus8.occ_vec, ev);
      check({nm, "_ones"}, bus8.ones, eo);
      check({nm, "_par"}, bus8.parity, ep);
      check({nm, "_busy_low"}, bus8.busy, 0);
      if (m == MODE_XOR)
         check({nm, "_xor_par"}, bus8.parity, 0);
      tick(1);
      check({nm, "_done_pulse"}, bus8.done, 0);
   endtask

   task automatic scan_model8(input string nm, input logic m);
      logic [7:0] ev;
      ev = model8(m);
      exp_q.push_back(ev);
      kick8(m);
      finish8(nm, m, 4'($countones(ev)), ^ev);
   endtask

   // driver tasks, 5x4 instance
   task automatic write5(input int a, input logic [3:0] d);
      bus5.wr_en   = 1'b1;
      bus5.wr_addr = 3'(a);
      bus5.wr_data = d;
      tick(1);
      bus5.wr_en = 1'b0;
      mdl5[a] = d;
   endtask

   task automatic scan5(input string nm, input logic m);
      int n, s0;
      logic [15:0] ev;
      exp5_q.push_back(model5(m));
      bus5.start = 1'b1;
      bus5.mode  = m;
      tick(1);
      bus5.start = 1'b0;
      s0 = cyc;
      n = 0;
      while (!bus5.done && n < 30) begin
         tick(1);
         n++;
      end
      check({nm, "_done"}, bus5.done, 1);
      check({nm, "_lat"}, cyc - s0, 6);
      ev = exp5_q.pop_front();
      check({nm, "_vec"}, bus5.occ_vec, ev);
      check({nm, "_ones"}, bus5.ones, $countones(ev));
      check({nm, "_par"}, bus5.parity, ^ev);
      if (m == MODE_XOR)
         check({nm, "_xor_par"}, bus5.parity, 1);
      check({nm, "_led"}, led5, ev[7:0]);
      tick(1);
   endtask

   initial begin
      int dn, d0, d1, d2;
      logic [7:0] ev;

      tbl[0] = '{data: {3'd2,3'd0,3'd5,3'd3,3'd2,3'd7,3'd4,3'd3}, mode: 1'b0, exp_vec: 8'hB1, exp_ones: 4'd4, exp_par: 1'b0};
      tbl[1] = '{data: {3'd2,3'd0,3'd5,3'd3,3'd2,3'd7,3'd4,3'd3}, mode: 1'b1, exp_vec: 8'hBD, exp_ones: 4'd6, exp_par: 1'b0};
      tbl[2] = '{data: {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, mode: 1'b0, exp_vec: 8'hFF, exp_ones: 4'd8, exp_par: 1'b0};
      tbl[3] = '{data: {8{3'd5}}, mode: 1'b1, exp_vec: 8'h20, exp_ones: 4'd1, exp_par: 1'b1};
      tbl[4] = '{data: {8{3'd5}}, mode: 1'b0, exp_vec: 8'h00, exp_ones: 4'd0, exp_par: 1'b0};
      tbl[5] = '{data: {3'd7,3'd7,3'd3,3'd2,3'd2,3'd1,3'd1,3'd1}, mode: 1'b0, exp_vec: 8'h0A, exp_ones: 4'd2, exp_par: 1'b0};
      tbl[6] = '{data: {3'd7,3'd7,3'd3,3'd2,3'd2,3'd1,3'd1,3'd1}, mode: 1'b1, exp_vec: 8'h8E, exp_ones: 4'd4, exp_par: 1'b0};

      rst = 1'b1;
      pb8 = 1'b0;
      pb5 = 1'b0;
      bus8.wr_en = 1'b0; bus8.wr_addr = '0; bus8.wr_data = '0; bus8.start = 1'b0; bus8.mode = 1'b0;
      bus5.wr_en = 1'b0; bus5.wr_addr = '0; bus5.wr_data = '0; bus5.start = 1'b0; bus5.mode = 1'b0;
      for (int i = 0; i < 8; i++) mdl8[i] = '0;
      for (int i = 0; i < 5; i++) mdl5[i] = '0;

      tick(2);
      check("rst_busy", bus8.busy, 0);
      check("rst_done", bus8.done, 0);
      check("rst_wr_err", bus8.wr_err, 0);
      check("rst_vec", bus8.occ_vec, 0);
      check("rst_par", bus8.parity, 0);
      check("rst_ones", bus8.ones, 0);
      check("rst_led", led8, 0);
      check("rst_state", bus8.fsm_state, 0);
      rst = 1'b0;
      tick(1);

      // table-driven scans
      for (int k = 0; k < NV; k++) begin
         load8(tbl[k].data);
         exp_q.push_back(tbl[k].exp_vec);
         kick8(tbl[k].mode);
         finish8($sformatf("vec%0d", k), tbl[k].mode, tbl[k].exp_ones, tbl[k].exp_par);
      end

      // display toggle on the OR-mode result
      load8(tbl[1].data);
      scan_model8("or_disp", 1'b1);
      check("led_vec", led8, 8'hBD);
      pb8 = 1'b1;
      tick(2);
      check("led_not_yet", led8, 8'hBD);
      tick(1);
      check("led_summary", led8, 8'h0C);
      pb8 = 1'b0;
      tick(3);
      pb8 = 1'b1;
      tick(3);
      check("led_back", led8, 8'hBD);
      pb8 = 1'b0;
      tick(3);

      // write during scan is dropped and flagged
      exp_q.push_back(model8(1'b0));
      kick8(1'b0);
      tick(1);
      bus8.wr_en   = 1'b1;
      bus8.wr_addr = 3'd2;
      bus8.wr_data = 3'd6;
      tick(1);
      bus8.wr_en = 1'b0;
      check("wr_err_pulse", bus8.wr_err, 1);
      tick(1);
      check("wr_err_clear", bus8.wr_err, 0);
      finish8("busy_write", 1'b0, 4'd4, 1'b0);

      // same write in idle is taken
      write8(2, 3'd6);
      ev = model8(1'b0);
      check("model_after_write", ev, 8'h71);
      scan_model8("idle_write", 1'b0);

      // write and start in the same cycle: scan sees the new value
      bus8.wr_en   = 1'b1;
      bus8.wr_addr = 3'd2;
      bus8.wr_data = 3'd7;
      mdl8[2]      = 3'd7;
      exp_q.push_back(model8(1'b0));
      bus8.start = 1'b1;
      bus8.mode  = 1'b0;
      tick(1);
      bus8.wr_en = 1'b0;
      bus8.start = 1'b0;
      t0 = cyc;
      finish8("wr_and_start", 1'b0, 4'd4, 1'b0);

      // start held high: one scan every DEPTH+2 cycles
      bus8.start = 1'b1;
      bus8.mode  = 1'b0;
      dn = 0; d0 = 0; d1 = 0; d2 = 0;
      for (int c = 1; c <= 30; c++) begin
         tick(1);
         if (bus8.done) begin
            check("held_vec", bus8.occ_vec, 8'hB1);
            if (dn == 0) d0 = c;
            else if (dn == 1) d1 = c;
            else d2 = c;
            dn++;
         end
      end
      bus8.start = 1'b0;
      check("held_count", dn, 3);
      check("held_first", d0, 10);
      check("held_gap1", d1 - d0, 10);
      check("held_gap2", d2 - d1, 10);
      tick(2);
      check("held_idle", bus8.busy, 0);

      // reset in the middle of a scan
      bus8.start = 1'b1;
      bus8.mode  = 1'b0;
      tick(1);
      bus8.start = 1'b0;
      tick(4);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", bus8.busy, 0);
      check("mid_rst_done", bus8.done, 0);
      check("mid_rst_vec", bus8.occ_vec, 0);
      check("mid_rst_ones", bus8.ones, 0);
      check("mid_rst_led", led8, 0);
      tick(1);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mdl8[i] = '0;
      for (int i = 0; i < 5; i++) mdl5[i] = '0;
      tick(1);
      check("post_rst_no_done", bus8.done, 0);
      scan_model8("zero_xor", 1'b0);
      scan_model8("zero_or", 1'b1);
      check("zero_or_vec", bus8.occ_vec, 8'h01);

      // 5x4 instance: random data and modes
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 5; i++)
            write5(i, 4'($urandom_range(0, 15)));
         scan5($sformatf("sweep%0d", r), 1'($urandom_range(0, 1)));
      end
      scan5("sweep_xor", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
